// File: rtl/bic_pkg.sv
// Shared definitions for the segmented bus-invert codec.
//   BIC_ENC / BIC_DEC : values of the mode input
//   popcount          : ones count of a vector, up to 64 bits wide (zero-extend narrower ones)
//   sat_add           : a + b clamped to 2^w - 1, for counters up to 64 bits wide
package bic_pkg;

   localparam logic BIC_ENC = 1'b0;
   localparam logic BIC_DEC = 1'b1;

   // Widest vector the helpers below accept.
   localparam int unsigned BIC_MAX_W = 64;

   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + {6'd0, v[i]};
      end
      return c;
   endfunction

   // The 65-bit intermediate keeps the sum from wrapping before it is clamped.
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [64:0] max;
      sum = {1'b0, a} + {1'b0, b};
      max = (65'd1 << w) - 65'd1;
      return (sum > max) ? max[63:0] : sum[63:0];
   endfunction

endpackage

// File: rtl/bic_seg_decide.sv
// Combinational invert decision for one bus segment.
//   seg_i      : raw segment to be sent
//   prev_seg_i : segment value currently driven on the bus
//   inv_prev_i : invert line value currently driven for this segment
//   inv_o      : new invert line value
//   out_seg_o  : segment value to drive (inverted when inv_o is set)
//   tgl_o      : number of data lines in this segment that toggle
module bic_seg_decide
   import bic_pkg::*;
#(
   parameter int unsigned SegW = 4
) (
   input  logic [SegW-1:0] seg_i,
   input  logic [SegW-1:0] prev_seg_i,
   input  logic            inv_prev_i,
   output logic            inv_o,
   output logic [SegW-1:0] out_seg_o,
   output logic [6:0]      tgl_o
);

   localparam logic [6:0] Half = 7'(SegW / 2);
   localparam logic [6:0] Full = 7'(SegW);

   logic [6:0] hd;

   always_comb begin
      hd = popcount(64'(seg_i ^ prev_seg_i));
      // On a tie both choices cost the same on the data lines, so keep the
      // invert line where it is and save its toggle.
      if (hd > Half) begin
         inv_o = 1'b1;
      end else if (hd == Half) begin
         inv_o = inv_prev_i;
      end else begin
         inv_o = 1'b0;
      end
      out_seg_o = inv_o ? ~seg_i : seg_i;
      tgl_o     = inv_o ? (Full - hd) : hd;
   end

endmodule

// File: rtl/bus_invert_codec_seg.sv
// Segmented bus-invert encoder/decoder with a valid/ready stream on each side.
//   clk, rst              : clock (rising edge) and synchronous active-low reset
//   mode                  : BIC_ENC / BIC_DEC, sampled with each accepted beat
//   in_valid/in_ready     : input handshake; in_data is the raw (encode) or bus (decode) word,
//                           in_inv the received invert lines (decode only)
//   out_valid/out_ready   : output handshake; out_data/out_inv held while stalled
//   clr_stats             : clears both counters, wins over a same-cycle increment
//   stat_raw_tgl          : data-line toggles the uncoded stream would have caused
//   stat_enc_tgl          : data + invert line toggles caused by the encoded stream
module bus_invert_codec_seg
   import bic_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NSEG  = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [NSEG-1:0]  in_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [NSEG-1:0]  out_inv,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] stat_raw_tgl,
   output logic [CNT_W-1:0] stat_enc_tgl
);

   localparam int unsigned SEG_W = WIDTH / NSEG;

   if (WIDTH % NSEG != 0) begin : g_err_div
      $error("WIDTH must be a multiple of NSEG");
   end
   if (SEG_W < 2) begin : g_err_segw
      $error("segment width must be at least 2");
   end
   if (WIDTH > BIC_MAX_W) begin : g_err_width
      $error("WIDTH exceeds the popcount helper range");
   end
   if (CNT_W == 0 || CNT_W > BIC_MAX_W) begin : g_err_cntw
      $error("CNT_W out of range");
   end

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [NSEG-1:0]  out_inv_q, out_inv_d;
   logic [WIDTH-1:0] bus_prev_q, bus_prev_d;
   logic [NSEG-1:0]  inv_prev_q, inv_prev_d;
   logic [WIDTH-1:0] raw_prev_q, raw_prev_d;
   logic [CNT_W-1:0] raw_cnt_q, raw_cnt_d;
   logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;

   logic             accept;
   logic [WIDTH-1:0] enc_data;
   logic [NSEG-1:0]  enc_inv;
   logic [WIDTH-1:0] dec_mask;
   logic [6:0]       seg_tgl [NSEG];
   logic [6:0]       raw_inc;
   logic [7:0]       enc_inc;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   for (genvar s = 0; s < NSEG; s++) begin : g_seg
      bic_seg_decide #(
         .SegW(SEG_W)
      ) u_decide (
         .seg_i      (in_data[s*SEG_W +: SEG_W]),
         .prev_seg_i (bus_prev_q[s*SEG_W +: SEG_W]),
         .inv_prev_i (inv_prev_q[s]),
         .inv_o      (enc_inv[s]),
         .out_seg_o  (enc_data[s*SEG_W +: SEG_W]),
         .tgl_o      (seg_tgl[s])
      );
      assign dec_mask[s*SEG_W +: SEG_W] = {SEG_W{in_inv[s]}};
   end

   always_comb begin
      raw_inc = popcount(64'(in_data ^ raw_prev_q));
      enc_inc = {1'b0, popcount(64'(enc_inv ^ inv_prev_q))};
      for (int s = 0; s < NSEG; s++) begin
         enc_inc = enc_inc + {1'b0, seg_tgl[s]};
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_inv_d   = out_inv_q;
      bus_prev_d  = bus_prev_q;
      inv_prev_d  = inv_prev_q;
      raw_prev_d  = raw_prev_q;
      raw_cnt_d   = raw_cnt_q;
      enc_cnt_d   = enc_cnt_q;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         if (mode == BIC_DEC) begin
            // Decode leaves all encoder history untouched.
            out_data_d = in_data ^ dec_mask;
            out_inv_d  = '0;
         end else begin
            out_data_d = enc_data;
            out_inv_d  = enc_inv;
            bus_prev_d = enc_data;
            inv_prev_d = enc_inv;
            raw_prev_d = in_data;
            raw_cnt_d  = CNT_W'(sat_add(64'(raw_cnt_q), 64'(raw_inc), CNT_W));
            enc_cnt_d  = CNT_W'(sat_add(64'(enc_cnt_q), 64'(enc_inc), CNT_W));
         end
      end

      if (clr_stats) begin
         raw_cnt_d = '0;
         enc_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_inv_q   <= '0;
         bus_prev_q  <= '0;
         inv_prev_q  <= '0;
         raw_prev_q  <= '0;
         raw_cnt_q   <= '0;
         enc_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_inv_q   <= out_inv_d;
         bus_prev_q  <= bus_prev_d;
         inv_prev_q  <= inv_prev_d;
         raw_prev_q  <= raw_prev_d;
         raw_cnt_q   <= raw_cnt_d;
         enc_cnt_q   <= enc_cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_inv      = out_inv_q;
   assign stat_raw_tgl = raw_cnt_q;
   assign stat_enc_tgl = enc_cnt_q;

endmodule

// File: tb/tb_bus_invert_codec_seg.sv
module tb_bus_invert_codec_seg;

   logic        clk;
   logic        rst;
   logic        mode;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_inv;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_inv;
   logic        clr_stats;
   logic [31:0] stat_raw_tgl;
   logic [31:0] stat_enc_tgl;

   // Second instance with narrow counters for saturation checks.
   logic        mode_s;
   logic        in_valid_s;
   logic        in_ready_s;
   logic [7:0]  in_data_s;
   logic [1:0]  in_inv_s;
   logic        out_valid_s;
   logic        out_ready_s;
   logic [7:0]  out_data_s;
   logic [1:0]  out_inv_s;
   logic        clr_stats_s;
   logic [3:0]  stat_raw_s;
   logic [3:0]  stat_enc_s;

   int checks;
   int errors;

   logic [9:0]  sb_q [$];
   logic [7:0]  m_bus;
   logic [1:0]  m_inv;
   logic [7:0]  m_raw;
   longint      m_raw_cnt;
   longint      m_enc_cnt;
   logic        rdy_stop;

   bus_invert_codec_seg #(
      .WIDTH(8),
      .NSEG (2),
      .CNT_W(32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_inv       (in_inv),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_inv      (out_inv),
      .clr_stats    (clr_stats),
      .stat_raw_tgl (stat_raw_tgl),
      .stat_enc_tgl (stat_enc_tgl)
   );

   bus_invert_codec_seg #(
      .WIDTH(8),
      .NSEG (2),
      .CNT_W(4)
   ) dut_s (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode_s),
      .in_valid     (in_valid_s),
      .in_ready     (in_ready_s),
      .in_data      (in_data_s),
      .in_inv       (in_inv_s),
      .out_valid    (out_valid_s),
      .out_ready    (out_ready_s),
      .out_data     (out_data_s),
      .out_inv      (out_inv_s),
      .clr_stats    (clr_stats_s),
      .stat_raw_tgl (stat_raw_s),
      .stat_enc_tgl (stat_enc_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model of one accepted beat on the 8-bit, two-segment instance.
   task automatic model_beat(input logic m, input logic [7:0] d, input logic [1:0] iv,
                             output logic [7:0] ed, output logic [1:0] ei);
      int         h;
      logic [3:0] sg;
      logic [3:0] pg;
      if (m) begin
         ed = d ^ {{4{iv[1]}}, {4{iv[0]}}};
         ei = 2'b00;
      end else begin
         for (int s = 0; s < 2; s++) begin
            sg = d[s*4 +: 4];
            pg = m_bus[s*4 +: 4];
            h  = $countones(sg ^ pg);
            ei[s] = (h > 2) ? 1'b1 : ((h == 2) ? m_inv[s] : 1'b0);
            ed[s*4 +: 4] = ei[s] ? ~sg : sg;
         end
         m_raw_cnt = m_raw_cnt + $countones(d ^ m_raw);
         m_enc_cnt = m_enc_cnt + $countones(ed ^ m_bus) + $countones(ei ^ m_inv);
         if (m_raw_cnt > 64'hFFFF_FFFF) m_raw_cnt = 64'hFFFF_FFFF;
         if (m_enc_cnt > 64'hFFFF_FFFF) m_enc_cnt = 64'hFFFF_FFFF;
         m_bus = ed;
         m_inv = ei;
         m_raw = d;
      end
   endtask

   // Scoreboard: a transfer happens at the posedge following a negedge with valid && ready.
   always @(negedge clk) begin
      logic [9:0] exp_v;
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got data=%h inv=%b, no beat expected",
                     out_data, out_inv);
         end else begin
            exp_v = sb_q.pop_front();
            if ({out_inv, out_data} !== exp_v) begin
               errors++;
               $display("FAIL sb_beat: got data=%h inv=%b, expected data=%h inv=%b",
                        out_data, out_inv, exp_v[7:0], exp_v[9:8]);
            end
         end
      end
   end

   // Called just after a posedge; returns just after the posedge that accepted the beat.
   task automatic send(input logic m, input logic [7:0] d, input logic [1:0] iv);
      logic [7:0] ed;
      logic [1:0] ei;
      int         n;
      mode     = m;
      in_data  = d;
      in_inv   = iv;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
      end else begin
         model_beat(m, d, iv, ed, ei);
         sb_q.push_back({ei, ed});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((sb_q.size() != 0 || out_valid !== 1'b0) && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (sb_q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain: pending=%0d out_valid=%b, expected 0 and 0",
                  sb_q.size(), out_valid);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_valid_s  = 1'b0;
      clr_stats   = 1'b0;
      clr_stats_s = 1'b0;
      out_ready   = 1'b1;
      out_ready_s = 1'b1;
      mode        = 1'b0;
      mode_s      = 1'b0;
      in_data     = 8'h00;
      in_data_s   = 8'h00;
      in_inv      = 2'b00;
      in_inv_s    = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      sb_q.delete();
      m_bus     = 8'h00;
      m_inv     = 2'b00;
      m_raw     = 8'h00;
      m_raw_cnt = 0;
      m_enc_cnt = 0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_inv !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b d=%h i=%b, expected 0 00 00",
                  out_valid, out_data, out_inv);
      end
      checks++;
      if (stat_raw_tgl !== 32'd0 || stat_enc_tgl !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got raw=%0d enc=%0d, expected 0 0",
                  stat_raw_tgl, stat_enc_tgl);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_encode_basic();
      do_reset();
      send(1'b0, 8'hFF, 2'b00);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || out_inv !== 2'b11) begin
         errors++;
         $display("FAIL enc_beat1: got v=%b d=%h i=%b, expected 1 00 11",
                  out_valid, out_data, out_inv);
      end
      @(posedge clk);
      #1;
      send(1'b0, 8'hF0, 2'b00);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || out_inv !== 2'b10) begin
         errors++;
         $display("FAIL enc_beat2: got v=%b d=%h i=%b, expected 1 00 10",
                  out_valid, out_data, out_inv);
      end
      checks++;
      if (stat_raw_tgl !== 32'd12 || stat_enc_tgl !== 32'd3) begin
         errors++;
         $display("FAIL enc_stats: got raw=%0d enc=%0d, expected 12 3",
                  stat_raw_tgl, stat_enc_tgl);
      end
      drain();
   endtask

   task automatic test_tie();
      do_reset();
      send(1'b0, 8'h33, 2'b00);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h33 || out_inv !== 2'b00) begin
         errors++;
         $display("FAIL tie: got v=%b d=%h i=%b, expected 1 33 00",
                  out_valid, out_data, out_inv);
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [7:0] ed;
      logic [1:0] ei;
      do_reset();
      out_ready = 1'b0;
      send(1'b0, 8'h01, 2'b00);
      mode     = 1'b0;
      in_data  = 8'h02;
      in_inv   = 2'b00;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01
             || out_inv !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h i=%b, expected 0 1 01 00",
                     i, in_ready, out_valid, out_data, out_inv);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b, expected 1", in_ready);
      end else begin
         model_beat(1'b0, 8'h02, 2'b00, ed, ei);
         sb_q.push_back({ei, ed});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h02 || out_inv !== 2'b00) begin
         errors++;
         $display("FAIL bp_beat_b: got v=%b d=%h i=%b, expected 1 02 00",
                  out_valid, out_data, out_inv);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_dup: out_valid=%b, expected 0", out_valid);
      end
      drain();
   endtask

   task automatic test_decode();
      do_reset();
      send(1'b1, 8'h0F, 2'b10);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF || out_inv !== 2'b00) begin
         errors++;
         $display("FAIL dec_beat: got v=%b d=%h i=%b, expected 1 FF 00",
                  out_valid, out_data, out_inv);
      end
      checks++;
      if (stat_raw_tgl !== 32'd0 || stat_enc_tgl !== 32'd0) begin
         errors++;
         $display("FAIL dec_counters: got raw=%0d enc=%0d, expected 0 0",
                  stat_raw_tgl, stat_enc_tgl);
      end
      @(posedge clk);
      #1;
      send(1'b0, 8'h00, 2'b11);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || out_inv !== 2'b00) begin
         errors++;
         $display("FAIL dec_then_enc: got v=%b d=%h i=%b, expected 1 00 00",
                  out_valid, out_data, out_inv);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic [1:0] iv;
      logic       m;
      do_reset();
      rdy_stop = 1'b0;
      fork
         begin
            while (!rdy_stop) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               m  = ($urandom_range(0, 3) == 0);
               d  = 8'($urandom_range(0, 255));
               iv = 2'($urandom_range(0, 3));
               send(m, d, iv);
            end
            rdy_stop = 1'b1;
         end
      join
      drain();
      checks++;
      if (stat_raw_tgl !== m_raw_cnt[31:0] || stat_enc_tgl !== m_enc_cnt[31:0]) begin
         errors++;
         $display("FAIL b2b_stats: got raw=%0d enc=%0d, expected %0d %0d",
                  stat_raw_tgl, stat_enc_tgl, m_raw_cnt, m_enc_cnt);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] pat [4];
      pat[0] = 8'h00;
      pat[1] = 8'hFF;
      pat[2] = 8'h00;
      pat[3] = 8'hFF;
      do_reset();
      // Expected raw toggles 0,8,8,8 -> clamps at 15; encoded 0,2,2,2 -> 6.
      for (int i = 0; i < 4; i++) begin
         mode_s     = 1'b0;
         in_data_s  = pat[i];
         in_valid_s = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid_s = 1'b0;
      @(negedge clk);
      checks++;
      if (stat_raw_s !== 4'd15) begin
         errors++;
         $display("FAIL sat_raw: got %0d, expected 15", stat_raw_s);
      end
      checks++;
      if (stat_enc_s !== 4'd6) begin
         errors++;
         $display("FAIL sat_enc: got %0d, expected 6", stat_enc_s);
      end
      @(posedge clk);
      #1;
      in_data_s   = 8'h00;
      in_valid_s  = 1'b1;
      clr_stats_s = 1'b1;
      @(posedge clk);
      #1;
      in_valid_s  = 1'b0;
      clr_stats_s = 1'b0;
      @(negedge clk);
      checks++;
      if (stat_raw_s !== 4'd0 || stat_enc_s !== 4'd0) begin
         errors++;
         $display("FAIL sat_clear: got raw=%0d enc=%0d, expected 0 0", stat_raw_s, stat_enc_s);
      end
      checks++;
      if (out_valid_s !== 1'b1 || out_data_s !== 8'h00 || out_inv_s !== 2'b00) begin
         errors++;
         $display("FAIL sat_clear_beat: got v=%b d=%h i=%b, expected 1 00 00",
                  out_valid_s, out_data_s, out_inv_s);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rdy_stop = 1'b0;
      test_reset();
      test_encode_basic();
      test_tie();
      test_backpressure();
      test_decode();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
